// File: rtl/simeck_round_ctrl.sv
// simeck_round_ctrl: Simeck32/64 sequencer (key expansion pass, round pass, start/busy/done).
// Define SIMECK_KEY_CACHE_EN to keep round keys across operations and skip KEYGEN when new_key = 0.
module simeck_round_ctrl #(
    parameter int ROUNDS = 32,
    parameter int AW     = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic          new_key,
    input  logic          z_in,
    output logic          lfsr_set,
    output logic          key_load,
    output logic          pt_load,
    output logic          kg_en,
    output logic          kg_const,
    output logic          rk_we,
    output logic [AW-1:0] rk_waddr,
    output logic          rk_re,
    output logic [AW-1:0] rk_raddr,
    output logic          round_en,
    output logic [AW-1:0] round_idx,
    output logic          busy,
    output logic          done
);
    typedef enum logic [2:0] {IDLE, LOAD, KEYGEN, PRIME, RUN, DONE} state_t;
    localparam logic [AW-1:0] LAST = AW'(ROUNDS - 1);
    state_t state;
    logic [AW-1:0] cnt, cnt1, cnt2;
    logic md, kp, keys_valid, need;
    assign cnt1 = cnt + AW'(1);
    assign cnt2 = cnt + AW'(2);
    assign need = new_key || !keys_valid;
    assign kg_const = z_in & kg_en;
`ifdef SIMECK_KEY_CACHE_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) keys_valid <= 1'b0;
        else if (state == KEYGEN && cnt == LAST) keys_valid <= 1'b1;
`else
    assign keys_valid = 1'b0;
`endif
    // Outputs are registered: each branch drives the values of the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            md        <= 1'b0;
            kp        <= 1'b0;
            lfsr_set  <= 1'b1;
            key_load  <= 1'b0;
            pt_load   <= 1'b0;
            kg_en     <= 1'b0;
            rk_we     <= 1'b0;
            rk_waddr  <= '0;
            rk_re     <= 1'b0;
            rk_raddr  <= '0;
            round_en  <= 1'b0;
            round_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            key_load  <= 1'b0;
            pt_load   <= 1'b0;
            kg_en     <= 1'b0;
            rk_we     <= 1'b0;
            rk_waddr  <= '0;
            rk_re     <= 1'b0;
            rk_raddr  <= '0;
            round_en  <= 1'b0;
            round_idx <= '0;
            done      <= 1'b0;
            lfsr_set  <= 1'b1;
            busy      <= 1'b1;
            case (state)
                IDLE: begin
                    busy <= start;
                    if (start) begin
                        state    <= LOAD;
                        md       <= mode;
                        kp       <= need;
                        pt_load  <= 1'b1;
                        key_load <= need;
                    end
                end
                LOAD: begin
                    if (kp) begin
                        state    <= KEYGEN;
                        cnt      <= '0;
                        lfsr_set <= 1'b0;
                        kg_en    <= 1'b1;
                        rk_we    <= 1'b1;
                    end else begin
                        state    <= PRIME;
                        rk_re    <= 1'b1;
                        rk_raddr <= md ? LAST : '0;
                    end
                end
                KEYGEN: begin
                    if (cnt == LAST) begin
                        state    <= PRIME;
                        rk_re    <= 1'b1;
                        rk_raddr <= md ? LAST : '0;
                    end else begin
                        cnt      <= cnt1;
                        lfsr_set <= 1'b0;
                        kg_en    <= 1'b1;
                        rk_we    <= 1'b1;
                        rk_waddr <= cnt1;
                    end
                end
                PRIME: begin
                    state    <= RUN;
                    cnt      <= '0;
                    lfsr_set <= 1'b0;
                    round_en <= 1'b1;
                    rk_re    <= ROUNDS > 1;
                    rk_raddr <= md ? LAST - AW'(1) : AW'(1);
                end
                RUN: begin
                    if (cnt == LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt       <= cnt1;
                        lfsr_set  <= 1'b0;
                        round_en  <= 1'b1;
                        round_idx <= cnt1;
                        // Prefetch the key for round cnt1+1; nothing left to read in the last round.
                        if (cnt1 != LAST) begin
                            rk_re    <= 1'b1;
                            rk_raddr <= md ? LAST - cnt2 : cnt2;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_simeck_round_ctrl.sv
// tb_simeck_round_ctrl: randomized bench for simeck_round_ctrl against a phase-based schedule model.
// Honours SIMECK_KEY_CACHE_EN the same way the design does.
module tb_simeck_round_ctrl;
    localparam int R  = 32;
    localparam int AW = 5;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0, new_key = 1'b0, z_in = 1'b0;
    logic lfsr_set, key_load, pt_load, kg_en, kg_const, rk_we, rk_re, round_en, busy, done;
    logic [AW-1:0] rk_waddr, rk_raddr, round_idx;
    int compared = 0, mismatched = 0;
    int we_cnt = 0, ren_cnt = 0, done_cnt = 0, cyc = 0;
    bit zpat = 1'b0;
    bit active = 1'b0, kp = 1'b0, md = 1'b0, kv = 1'b0;
    int t = 0;

    simeck_round_ctrl #(.ROUNDS(R), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .new_key(new_key), .z_in(z_in),
        .lfsr_set(lfsr_set), .key_load(key_load), .pt_load(pt_load), .kg_en(kg_en),
        .kg_const(kg_const), .rk_we(rk_we), .rk_waddr(rk_waddr), .rk_re(rk_re),
        .rk_raddr(rk_raddr), .round_en(round_en), .round_idx(round_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc++;
        z_in = zpat ? cyc[0] : 1'($urandom);
    end

    // Model: an operation is a timeline of phases t = 1.. counted from the sampling edge.
    initial forever begin
        int p, dn, i;
        bit kg, pr, rn, rd;
        logic [24:0] ex, ac;
        @(negedge clk);
        if (reset) begin
            active = 1'b0;
            kv = 1'b0;
        end
        p  = kp ? R + 2 : 2;
        dn = p + R + 1;
        i  = t - p - 1;
        kg = active && kp && t >= 2 && t <= R + 1;
        pr = active && t == p;
        rn = active && t > p && t <= p + R;
        rd = rn && i < R - 1;
        ex = {!active || t == 1 || t == p || t == dn, active && t == 1 && kp, active && t == 1,
              kg, kg && z_in, kg, kg ? 5'(t - 2) : 5'd0,
              pr || rd, pr ? (md ? 5'(R - 1) : 5'd0) : rd ? (md ? 5'(R - 2 - i) : 5'(i + 1)) : 5'd0,
              rn, rn ? 5'(i) : 5'd0, active, active && t == dn};
        ac = {lfsr_set, key_load, pt_load, kg_en, kg_const, rk_we, rk_waddr, rk_re, rk_raddr,
              round_en, round_idx, busy, done};
        compared++;
        if (ac !== ex) begin
            mismatched++;
            $display("FAIL outputs t=%0d phase=%0d: got %h expected %h", $time, t, ac, ex);
        end
        we_cnt   += int'(rk_we);
        ren_cnt  += int'(round_en);
        done_cnt += int'(done);
        if (!reset) begin
            if (active) begin
                if (kp && t == R + 1) kv = 1'b1;
                if (t == dn) active = 1'b0;
                else t++;
            end else if (start) begin
                active = 1'b1;
                t = 1;
                md = mode;
`ifdef SIMECK_KEY_CACHE_EN
                kp = new_key || !kv;
`else
                kp = 1'b1;
`endif
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // exp_lat < 0 skips the literal latency check; poke pulses start during RUN.
    task automatic run_op(input bit m, input bit nk, input int exp_lat, input bit poke);
        int n = 0, d0 = done_cnt;
        bit seen = 1'b0;
        start = 1'b1; mode = m; new_key = nk;
        tick;
        start = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            seen = done;
            if (!seen) begin
                @(posedge clk);
                #1;
                start = poke && (n == 39 || n == 40);
                mode = 1'($urandom);
                new_key = 1'($urandom);
            end
        end
        tick;
        start = 1'b0;
        if (!seen) check("done timeout", 0, 1);
        else if (exp_lat >= 0) check("done latency", n, exp_lat);
        check("done count", done_cnt - d0, 1);
    endtask

    initial begin
        int w0, r0;
        repeat (3) tick;
        reset = 1'b0;
        tick;
        w0 = we_cnt; r0 = ren_cnt;
        run_op(1'b0, 1'b1, 67, 1'b0);
        check("keygen writes", we_cnt - w0, 32);
        check("round enables", ren_cnt - r0, 32);
`ifdef SIMECK_KEY_CACHE_EN
        run_op(1'b1, 1'b0, 35, 1'b0);
`else
        run_op(1'b1, 1'b0, 67, 1'b0);
`endif
        start = 1'b1; mode = 1'b0; new_key = 1'b1;
        tick;
        start = 1'b0;
        repeat (11) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tick;
        run_op(1'b0, 1'b0, 67, 1'b0);
        zpat = 1'b1;
        run_op(1'b1, 1'b1, 67, 1'b1);
        zpat = 1'b0;
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 3)) tick;
            run_op(1'($urandom), 1'($urandom), -1, 1'($urandom));
        end
        repeat (3) tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/simeck_round_ctrl.md
# simeck_round_ctrl

Sequencing controller for the Simeck32/64 encrypter-decrypter core.
- Drives the `set` input of the 5-bit round-constant LFSR and forwards its `z` bit to the key-schedule datapath.
- Runs a 32-cycle key-expansion pass into the round-key RAM, then a 32-cycle round pass that reads keys ascending for encryption or descending for decryption.
- Handshake with the host is start/busy/done.

## Interface
- ROUNDS, 32: number of Simeck rounds and round keys.
- AW, 5: round-key RAM address width; ROUNDS ≤ 2**AW.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin an operation; sampled only in IDLE.
- mode  in  1  0 = encrypt, 1 = decrypt; captured with start.
- new_key  in  1  1 = run key expansion; captured with start.
- z_in  in  1  LFSR output bit.
- lfsr_set  out  1  drives the LFSR `set` input; holds the LFSR at its seed.
- key_load  out  1  one-cycle pulse: load master key into the key-schedule registers.
- pt_load  out  1  one-cycle pulse: load the input block into the data registers.
- kg_en  out  1  key-schedule step enable.
- kg_const  out  1  round-constant bit; equals z_in & kg_en.
- rk_we  out  1  round-key RAM write enable.
- rk_waddr  out  AW  write address.
- rk_re  out  1  round-key RAM read enable; the RAM has one-cycle read latency.
- rk_raddr  out  AW  read address.
- round_en  out  1  data-path round enable.
- round_idx  out  AW  current round number, 0..ROUNDS-1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- States and transitions:
  - IDLE → LOAD when start = 1.
  - LOAD (1 cycle) → KEYGEN if a key pass is required, else → PRIME.
  - KEYGEN (ROUNDS cycles) → PRIME.
  - PRIME (1 cycle) → RUN.
  - RUN (ROUNDS cycles) → DONE.
  - DONE (1 cycle) → IDLE.
- A key pass is required when new_key = 1 or keys_valid = 0. keys_valid is an internal flag: cleared by reset, set on the last KEYGEN cycle.
- IDLE, LOAD:
  - lfsr_set = 1.
  - In LOAD: pt_load = 1; key_load = 1 only if KEYGEN follows.
- KEYGEN, cycle k = 0..ROUNDS-1:
  - lfsr_set = 0 (the LFSR free-runs one bit per cycle, so KEYGEN never stalls).
  - kg_en = 1, rk_we = 1, rk_waddr = k.
- PRIME:
  - lfsr_set = 1, rk_re = 1.
  - rk_raddr = 0 for encrypt, ROUNDS-1 for decrypt.
- RUN, cycle i:
  - round_en = 1, round_idx = i.
  - For i < ROUNDS-1: rk_re = 1, rk_raddr = i+1 (encrypt) or ROUNDS-2-i (decrypt).
  - On the last cycle: rk_re = 0.
- DONE: done = 1, lfsr_set = 1.
- mode and new_key are latched in IDLE when start is accepted; changes while busy are ignored.
- start while busy is ignored and is not queued.
- Counter arithmetic is AW-bit unsigned. Decrypt addresses are computed as ROUNDS-1-n, never by wrap-around.
- Unless stated otherwise above, every output is 0.

## Timing
- Reset values (asynchronous): state = IDLE, lfsr_set = 1, busy = 0, done = 0, keys_valid = 0, and every other output 0.
- Reset mid-operation aborts immediately. keys_valid is cleared, so the next start always runs KEYGEN.
- Latency, counted from the edge that samples start as edge 0:
  - With KEYGEN: done is high in the cycle after edge 2·ROUNDS+2 (cycle 67 for ROUNDS = 32).
  - Without KEYGEN: done is high in cycle ROUNDS+3 (35).
- busy rises in the cycle after start is sampled and falls in the cycle after done.
- Back-to-back operation: start may be asserted in the first IDLE cycle after DONE.
- kg_const is combinational from z_in. All other outputs are registered or decoded from state only.

## Configuration
- SIMECK_KEY_CACHE_EN defined:
  - keys_valid is implemented.
  - new_key = 0 with keys_valid = 1 skips KEYGEN and reuses the round keys already in RAM.
- Not defined:
  - keys_valid is tied to 0.
  - Every operation runs KEYGEN; new_key is ignored.

## Test plan
- Reset, then encrypt with new_key = 1:
  - key_load and pt_load pulse in cycle 1.
  - rk_we is high in cycles 2–33 with rk_waddr 0..31.
  - round_en is high in cycles 35–66.
  - done is high in cycle 67.
- Decrypt following it with new_key = 0 (macro defined):
  - No KEYGEN; done is high in cycle 35.
  - PRIME reads address 31; RUN reads 30..0.
- Same decrypt sequence with the macro undefined: KEYGEN runs and done is high in cycle 67.
- Assert reset during KEYGEN cycle 10, then start with new_key = 0: full KEYGEN runs and lfsr_set is 1 until KEYGEN begins.
- Drive z_in = 1010… during KEYGEN: kg_const equals z_in there, and kg_const = 0 in all other states.
- Pulse start during RUN: ignored, busy stays high, and exactly one done is produced.
